// File: rtl/morse_letter_decoder.sv
// morse_letter_decoder: times key marks/spaces in ticks, classifies dots/dashes, decodes letters A-Z
module morse_letter_decoder #(
    parameter int DOT_MAX    = 2,
    parameter int LETTER_GAP = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       tick,
    input  logic       key,
    output logic       letter_valid,
    output logic [4:0] letter,
    output logic [2:0] symbol_count,
    output logic       busy
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] MARK  = 2'd1;
    localparam logic [1:0] SPACE = 2'd2;
    localparam logic [7:0] DOT_LIM = 8'(DOT_MAX);
    localparam logic [7:0] GAP_LIM = 8'(LETTER_GAP);

    logic [1:0] state;
    logic [7:0] mark_cnt, gap_cnt;
    logic [3:0] pattern;
    logic       overflow;
    logic [4:0] decoded;

    assign busy = state != IDLE;

    // Shorter letters keep zeros above their symbols, so count+pattern is a unique key
    always_comb begin
        decoded = 5'd31;
        if (!overflow)
            case ({symbol_count, pattern})
                {3'd1, 4'b0000}: decoded = 5'd4;
                {3'd1, 4'b0001}: decoded = 5'd19;
                {3'd2, 4'b0001}: decoded = 5'd0;
                {3'd2, 4'b0000}: decoded = 5'd8;
                {3'd2, 4'b0011}: decoded = 5'd12;
                {3'd2, 4'b0010}: decoded = 5'd13;
                {3'd3, 4'b0100}: decoded = 5'd3;
                {3'd3, 4'b0110}: decoded = 5'd6;
                {3'd3, 4'b0101}: decoded = 5'd10;
                {3'd3, 4'b0111}: decoded = 5'd14;
                {3'd3, 4'b0010}: decoded = 5'd17;
                {3'd3, 4'b0000}: decoded = 5'd18;
                {3'd3, 4'b0001}: decoded = 5'd20;
                {3'd3, 4'b0011}: decoded = 5'd22;
                {3'd4, 4'b1000}: decoded = 5'd1;
                {3'd4, 4'b1010}: decoded = 5'd2;
                {3'd4, 4'b0010}: decoded = 5'd5;
                {3'd4, 4'b0000}: decoded = 5'd7;
                {3'd4, 4'b0111}: decoded = 5'd9;
                {3'd4, 4'b0100}: decoded = 5'd11;
                {3'd4, 4'b0110}: decoded = 5'd15;
                {3'd4, 4'b1101}: decoded = 5'd16;
                {3'd4, 4'b0001}: decoded = 5'd21;
                {3'd4, 4'b1001}: decoded = 5'd23;
                {3'd4, 4'b1011}: decoded = 5'd24;
                {3'd4, 4'b1100}: decoded = 5'd25;
                default:         decoded = 5'd31;
            endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            mark_cnt     <= '0;
            gap_cnt      <= '0;
            pattern      <= '0;
            overflow     <= 1'b0;
            symbol_count <= '0;
            letter       <= '0;
            letter_valid <= 1'b0;
        end else begin
            letter_valid <= 1'b0;
            if (tick)
                case (state)
                    IDLE: if (key) begin
                        state    <= MARK;
                        mark_cnt <= 8'd1;
                    end
                    MARK: if (key) begin
                        mark_cnt <= (mark_cnt == 8'd255) ? mark_cnt : mark_cnt + 8'd1;
                    end else begin
                        if (symbol_count < 3'd4) begin
                            pattern      <= {pattern[2:0], mark_cnt > DOT_LIM};
                            symbol_count <= symbol_count + 3'd1;
                        end else
                            overflow <= 1'b1;
                        state   <= SPACE;
                        gap_cnt <= 8'd1;
                    end
                    SPACE: if (key) begin
                        state    <= MARK;
                        mark_cnt <= 8'd1;
                        gap_cnt  <= '0;
                    end else begin
                        gap_cnt <= gap_cnt + 8'd1;
                        if (gap_cnt + 8'd1 == GAP_LIM) begin
                            letter_valid <= 1'b1;
                            letter       <= decoded;
                            pattern      <= '0;
                            symbol_count <= '0;
                            overflow     <= 1'b0;
                            state        <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_morse_letter_decoder.sv
// tb_morse_letter_decoder: scoreboard bench with a string-based Morse reference model
module tb_morse_letter_decoder;
    localparam int DOT_MAX    = 2;
    localparam int LETTER_GAP = 3;

    logic       clock = 1'b0, reset = 1'b1, tick = 1'b0, key = 1'b0;
    logic       letter_valid, busy;
    logic [4:0] letter;
    logic [2:0] symbol_count;

    always #5 clock = ~clock;

    morse_letter_decoder #(.DOT_MAX(DOT_MAX), .LETTER_GAP(LETTER_GAP)) dut (
        .clock(clock), .reset(reset), .tick(tick), .key(key),
        .letter_valid(letter_valid), .letter(letter),
        .symbol_count(symbol_count), .busy(busy)
    );

    string morse [26] = '{".-", "-...", "-.-.", "-..", ".", "..-.", "--.", "....", "..", ".---",
                          "-.-", ".-..", "--", "-.", "---", ".--.", "--.-", ".-.", "...", "-",
                          "..-", "...-", ".--", "-..-", "-.--", "--.."};
    int n_checks = 0, n_fail = 0;
    int exp_q[$];
    int idle_max = 0;
    int marks[8];
    bit prev_valid = 1'b0;

    function automatic int ref_letter(input int n);
        string s = "";
        for (int i = 0; i < n; i++) s = $sformatf("%s%s", s, marks[i] > DOT_MAX ? "-" : ".");
        if (n > 4) return 31;
        for (int k = 0; k < 26; k++) if (s == morse[k]) return k;
        return 31;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tk(input bit k);
        key  = k;
        tick = 1'b1;
        @(posedge clock); #1;
        tick = 1'b0;
        repeat ($urandom_range(idle_max, 0)) begin
            @(posedge clock); #1;
        end
    endtask

    task automatic mark(input int n); repeat (n) tk(1'b1); endtask
    task automatic gap(input int n);  repeat (n) tk(1'b0); endtask

    task automatic send(input int n);
        exp_q.push_back(ref_letter(n));
        for (int i = 0; i < n; i++) begin
            mark(marks[i]);
            gap(i == n - 1 ? LETTER_GAP : $urandom_range(LETTER_GAP - 1, 1));
        end
    endtask

    // Monitor: every strobe must be single-cycle and match the oldest expected letter
    always @(negedge clock) begin
        if (letter_valid) begin
            chk("strobe_width", int'(prev_valid), 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_strobe: got letter %0d expected no strobe", letter);
            end else
                chk("letter", int'(letter), exp_q.pop_front());
        end
        prev_valid = letter_valid;
    end

    initial begin
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_valid", int'(letter_valid), 0);
        chk("rst_letter", int'(letter), 0);
        chk("rst_count", int'(symbol_count), 0);
        chk("rst_busy", int'(busy), 0);

        exp_q.push_back(0);
        tk(1'b1); tk(1'b0);
        chk("A_count1", int'(symbol_count), 1);
        mark(3); tk(1'b0);
        chk("A_count2", int'(symbol_count), 2);
        chk("A_busy", int'(busy), 1);
        gap(2);
        chk("A_count0", int'(symbol_count), 0);
        chk("A_idle", int'(busy), 0);
        chk("A_letter", int'(letter), 0);

        marks[0] = DOT_MAX;     send(1); chk("E_letter", int'(letter), 4);
        marks[0] = DOT_MAX + 1; send(1); chk("T_letter", int'(letter), 19);

        exp_q.push_back(18);
        mark(1); gap(2);
        chk("S_intra_busy", int'(busy), 1);
        chk("S_intra_count", int'(symbol_count), 1);
        mark(1); gap(2); mark(1); gap(3);
        chk("S_letter", int'(letter), 18);

        marks[0:3] = '{1, 1, 3, 3}; send(4); chk("inv_letter", int'(letter), 31);
        exp_q.push_back(31);
        for (int i = 0; i < 5; i++) begin
            mark(1); tk(1'b0);
        end
        chk("ovf_count", int'(symbol_count), 4);
        gap(LETTER_GAP - 1);
        chk("ovf_letter", int'(letter), 31);
        marks[0] = 3; send(1); chk("ovf_clear", int'(letter), 19);

        mark(3); gap(1); mark(3); gap(1);
        reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("mid_rst_valid", int'(letter_valid), 0);
        chk("mid_rst_letter", int'(letter), 0);
        chk("mid_rst_count", int'(symbol_count), 0);
        chk("mid_rst_busy", int'(busy), 0);
        marks[0] = 1; send(1); chk("post_rst_E", int'(letter), 4);

        idle_max = 7;
        marks[0:1] = '{1, 3}; send(2); chk("gated_A", int'(letter), 0);

        idle_max = 0;
        exp_q.push_back(19);
        mark(300);
        chk("hold_busy", int'(busy), 1);
        chk("hold_count", int'(symbol_count), 0);
        gap(LETTER_GAP);
        gap(10);
        chk("idle_hold_letter", int'(letter), 19);
        chk("idle_busy", int'(busy), 0);

        idle_max = 3;
        for (int l = 0; l < 40; l++) begin
            int n;
            if ($urandom_range(3, 0) == 0) begin
                n = $urandom_range(6, 1);
                for (int i = 0; i < n; i++) marks[i] = $urandom_range(DOT_MAX + 6, 1);
            end else begin
                string s = morse[$urandom_range(25, 0)];
                n = s.len();
                for (int i = 0; i < n; i++)
                    marks[i] = (s.getc(i) == 8'h2D) ? $urandom_range(DOT_MAX + 6, DOT_MAX + 1)
                                                    : $urandom_range(DOT_MAX, 1);
            end
            send(n);
        end

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clock);
        chk("pending_strobes", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
